// File: rtl/ddram_rom_pkg.sv
// Shared types and helpers for the cartridge ROM DDR3 port.
// The port moves 16-bit ROM words between a toggle handshake and single 64-bit DDR beats.
package ddram_rom_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT
  } state_t;

  localparam logic [28:0] DDR_BASE_DEFAULT = 29'h0600000;

  // Byte enables for 16-bit word k of a 64-bit line
  function automatic logic [7:0] be_for_word(input logic [1:0] k);
    return 8'b0000_0011 << {k, 1'b0};
  endfunction

  function automatic logic [15:0] word_sel(input logic [63:0] line, input logic [1:0] k);
    return line[{k, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/ddram_line_cache.sv
// One-line (64-bit) read cache: a tag, the line data and a valid bit.
// It is filled from a DDR read beat and dropped when a write lands on the cached line.
module ddram_line_cache
  import ddram_rom_pkg::*;
(
  input  logic        CLK_VIDEO,
  input  logic        reset,
  input  logic        fill,
  input  logic [19:0] fill_tag,
  input  logic [63:0] fill_line,
  input  logic        inv,
  input  logic [21:0] inv_line,
  input  logic [19:0] lookup_tag,
  input  logic [1:0]  lookup_k,
  output logic        hit,
  output logic [15:0] word
);

  logic        valid;
  logic [19:0] tag;
  logic [63:0] line;

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
    end else if (inv && (inv_line == {2'b00, tag})) begin
      valid <= 1'b0;
    end
  end

  // NOTE: tag/line carry no reset; they are only observed while valid=1, and valid is reset.
  always_ff @(posedge CLK_VIDEO) begin
    if (fill) begin
      tag  <= fill_tag;
      line <= fill_line;
    end
  end

  assign hit  = valid && (tag == lookup_tag);
  assign word = word_sel(line, lookup_k);

endmodule

// File: rtl/ddram_rom_port.sv
// Cartridge ROM store port: toggle-handshake ROM writes and cached ROM reads
// onto single-beat DDR3 Avalon transactions, all in the CLK_VIDEO domain.
module ddram_rom_port
  import ddram_rom_pkg::*;
#(
  parameter logic [28:0] DDR_BASE = DDR_BASE_DEFAULT,
  parameter bit          RD_PRIO  = 1'b0
) (
  input  logic        CLK_VIDEO,
  input  logic        reset,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  input  logic [24:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,
  input  logic [21:0] rdaddr,
  output logic [15:0] dout,
  input  logic        rd_req,
  output logic        rd_ack
);

  state_t state_q, state_d;

  logic        wr_pend, rd_pend, wr_first;
  logic        start_wr, hit_rd, start_rd, wr_done, rd_issued, rd_fill;
  logic        cache_hit;
  logic [15:0] cache_word;
  logic [21:0] wr_line_q;
  logic [19:0] rd_line_q;
  logic [1:0]  rd_k_q;
  logic        wraddr_unused;

  assign wraddr_unused  = wraddr[0];
  assign DDRAM_BURSTCNT = 8'd1;

  assign wr_pend  = we_req ^ we_ack;
  assign rd_pend  = rd_req ^ rd_ack;
  assign wr_first = wr_pend && !(RD_PRIO && rd_pend);

  ddram_line_cache u_cache (
    .CLK_VIDEO (CLK_VIDEO),
    .reset     (reset),
    .fill      (rd_fill),
    .fill_tag  (rd_line_q),
    .fill_line (DDRAM_DOUT),
    .inv       (wr_done),
    .inv_line  (wr_line_q),
    .lookup_tag(rdaddr[21:2]),
    .lookup_k  (rdaddr[1:0]),
    .hit       (cache_hit),
    .word      (cache_word)
  );

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    start_wr  = 1'b0;
    hit_rd    = 1'b0;
    start_rd  = 1'b0;
    wr_done   = 1'b0;
    rd_issued = 1'b0;
    rd_fill   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_first) begin
          start_wr = 1'b1;
          state_d  = WR;
        end else if (rd_pend) begin
          if (cache_hit) begin
            hit_rd = 1'b1;
          end else begin
            start_rd = 1'b1;
            state_d  = RD;
          end
        end
      end
      WR: begin
        if (!DDRAM_BUSY) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      RD: begin
        if (!DDRAM_BUSY) begin
          rd_issued = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Ready beats are only honoured here, so a beat left over from before a reset is dropped
        if (DDRAM_DOUT_READY) begin
          rd_fill = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      we_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_BE   <= 8'd0;
      DDRAM_ADDR <= 29'd0;
      DDRAM_DIN  <= 64'd0;
      dout       <= 16'd0;
      wr_line_q  <= 22'd0;
      rd_line_q  <= 20'd0;
      rd_k_q     <= 2'd0;
    end else begin
      if (start_wr) begin
        DDRAM_ADDR <= DDR_BASE + {7'd0, wraddr[24:3]};
        DDRAM_DIN  <= {4{din}};
        DDRAM_BE   <= be_for_word(wraddr[2:1]);
        DDRAM_WE   <= 1'b1;
        wr_line_q  <= wraddr[24:3];
      end
      if (wr_done) begin
        DDRAM_WE <= 1'b0;
        we_ack   <= ~we_ack;
      end
      if (hit_rd) begin
        dout   <= cache_word;
        rd_ack <= ~rd_ack;
      end
      if (start_rd) begin
        DDRAM_ADDR <= DDR_BASE + {9'd0, rdaddr[21:2]};
        DDRAM_RD   <= 1'b1;
        rd_line_q  <= rdaddr[21:2];
        rd_k_q     <= rdaddr[1:0];
      end
      if (rd_issued) begin
        DDRAM_RD <= 1'b0;
      end
      if (rd_fill) begin
        dout   <= word_sel(DDRAM_DOUT, rd_k_q);
        rd_ack <= ~rd_ack;
      end
    end
  end

endmodule

// File: tb/tb_ddram_rom_port.sv
// Bench for ddram_rom_port: a DDR3 slave model with programmable busy/latency and a
// word-level ROM reference model that predicts every read word and every required miss.
module tb_ddram_rom_port;

  localparam logic [28:0] BASE = 29'h0600000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ddr_busy = 1'b0;
  logic [7:0]  ddr_burstcnt;
  logic [28:0] ddr_addr;
  logic [63:0] ddr_dout = 64'd0;
  logic        ddr_ready = 1'b0;
  logic        ddr_rd;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_be;
  logic        ddr_we;
  logic [24:0] wraddr = 25'd0;
  logic [15:0] din = 16'd0;
  logic        we_req = 1'b0;
  logic        we_ack;
  logic [21:0] rdaddr = 22'd0;
  logic [15:0] dout;
  logic        rd_req = 1'b0;
  logic        rd_ack;

  int errors = 0;
  int checks = 0;

  ddram_rom_port #(.DDR_BASE(BASE), .RD_PRIO(1'b0)) dut (
    .CLK_VIDEO       (clk),
    .reset           (reset),
    .DDRAM_BUSY      (ddr_busy),
    .DDRAM_BURSTCNT  (ddr_burstcnt),
    .DDRAM_ADDR      (ddr_addr),
    .DDRAM_DOUT      (ddr_dout),
    .DDRAM_DOUT_READY(ddr_ready),
    .DDRAM_RD        (ddr_rd),
    .DDRAM_DIN       (ddr_din),
    .DDRAM_BE        (ddr_be),
    .DDRAM_WE        (ddr_we),
    .wraddr          (wraddr),
    .din             (din),
    .we_req          (we_req),
    .we_ack          (we_ack),
    .rdaddr          (rdaddr),
    .dout            (dout),
    .rd_req          (rd_req),
    .rd_ack          (rd_ack)
  );

  always #5 clk = ~clk;

  // ---------------- ROM content reference ----------------
  logic [63:0] ddr_mem [int unsigned];
  logic [15:0] wmodel  [int unsigned];
  bit          m_valid = 1'b0;
  int unsigned m_line  = 0;

  function automatic logic [15:0] init_word(input int unsigned line, input int unsigned k);
    return 16'(line * 37 + k * 4099 + 32'h1234);
  endfunction

  function automatic logic [63:0] ddr_line(input logic [28:0] a);
    int unsigned l = int'(a - BASE);
    if (ddr_mem.exists(int'(a))) return ddr_mem[int'(a)];
    return {init_word(l, 3), init_word(l, 2), init_word(l, 1), init_word(l, 0)};
  endfunction

  function automatic logic [15:0] model_word(input int unsigned w);
    if (wmodel.exists(w)) return wmodel[w];
    return init_word(w >> 2, w & 3);
  endfunction

  // ---------------- DDR3 slave model ----------------
  int  busy_cycles = 0;
  int  rd_latency  = 7;
  int  busy_left   = 0;
  bit  in_req      = 1'b0;
  int  rd_cnt      = 0;
  logic [28:0] rd_addr_q = 29'd0;
  int  rd_issues   = 0;
  int  wr_accepts  = 0;
  byte txn_log[$];

  always @(negedge clk) begin
    logic [63:0] cur;
    ddr_ready = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        ddr_ready = 1'b1;
        ddr_dout  = ddr_line(rd_addr_q);
      end
    end
    if (!(ddr_rd || ddr_we)) begin
      in_req   = 1'b0;
      ddr_busy = 1'b0;
    end else begin
      if (!in_req) begin
        in_req    = 1'b1;
        busy_left = busy_cycles;
      end
      if (busy_left > 0) begin
        ddr_busy = 1'b1;
        busy_left--;
      end else begin
        ddr_busy = 1'b0;
        if (ddr_we) begin
          cur = ddr_line(ddr_addr);
          for (int b = 0; b < 8; b++)
            if (ddr_be[b]) cur[8*b +: 8] = ddr_din[8*b +: 8];
          ddr_mem[int'(ddr_addr)] = cur;
          wr_accepts++;
          txn_log.push_back("W");
        end else begin
          rd_addr_q = ddr_addr;
          rd_cnt    = rd_latency;
          rd_issues++;
          txn_log.push_back("R");
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [24:0] a, input logic [15:0] d, input int busy,
                             output int cyc, output bit stable, output logic f_we,
                             output logic [28:0] f_addr, output logic [7:0] f_be,
                             output logic [63:0] f_din);
    busy_cycles = busy;
    wraddr = a;
    din    = d;
    we_req = ~we_req;
    wmodel[int'(a[24:1])] = d;
    if (m_valid && m_line == int'(a[24:3])) m_valid = 1'b0;
    cyc = 0;
    stable = 1'b1;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        f_we = ddr_we; f_addr = ddr_addr; f_be = ddr_be; f_din = ddr_din;
      end else if (we_ack !== we_req) begin
        if (ddr_we !== 1'b1 || ddr_addr !== f_addr) stable = 1'b0;
      end
    end while (we_ack !== we_req && cyc < 200);
    checks++;
    if (we_ack !== we_req) begin
      errors++;
      $display("FAIL write_timeout: we_ack=%b required %b", we_ack, we_req);
    end
  endtask

  task automatic issue_read(input logic [21:0] a, output logic [15:0] d, output int cyc,
                            output int new_rds, output bit must_miss, output bit ack_on_ready,
                            output logic f_rd, output logic [28:0] f_addr);
    int   rd0 = rd_issues;
    logic pr = 1'b0;
    must_miss = !(m_valid && m_line == int'(a[21:2]));
    rdaddr = a;
    rd_req = ~rd_req;
    cyc = 0;
    do begin
      pr = ddr_ready;
      tick();
      cyc++;
      if (cyc == 1) begin
        f_rd = ddr_rd; f_addr = ddr_addr;
      end
    end while (rd_ack !== rd_req && cyc < 200);
    ack_on_ready = pr;
    d = dout;
    new_rds = rd_issues - rd0;
    m_valid = 1'b1;
    m_line  = int'(a[21:2]);
    checks++;
    if (rd_ack !== rd_req) begin
      errors++;
      $display("FAIL read_timeout: rd_ack=%b required %b", rd_ack, rd_req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if ({we_ack, rd_ack, ddr_rd, ddr_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: ack/rd/we=%b required 0000", {we_ack, rd_ack, ddr_rd, ddr_we});
    end
    checks++;
    if (ddr_addr !== 29'd0 || ddr_be !== 8'd0 || ddr_din !== 64'd0 || dout !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h be=%h din=%h dout=%h required all zero",
               ddr_addr, ddr_be, ddr_din, dout);
    end
    checks++;
    if (ddr_burstcnt !== 8'd1) begin
      errors++;
      $display("FAIL burstcnt: got %h required 01", ddr_burstcnt);
    end
  endtask

  task automatic test_write_basic();
    int cyc; bit st; logic fwe; logic [28:0] fa; logic [7:0] fb; logic [63:0] fd;
    int w0 = wr_accepts;
    issue_write(25'h000006, 16'hA55A, 0, cyc, st, fwe, fa, fb, fd);
    checks++;
    if (fwe !== 1'b1 || fa !== 29'h0600000) begin
      errors++;
      $display("FAIL wr_issue: we=%b addr=%h required 1 0600000", fwe, fa);
    end
    checks++;
    if (fb !== 8'hC0 || fd !== 64'hA55AA55AA55AA55A) begin
      errors++;
      $display("FAIL wr_lane: be=%h din=%h required c0 a55aa55aa55aa55a", fb, fd);
    end
    checks++;
    if (cyc !== 2 || ddr_we !== 1'b0 || wr_accepts - w0 !== 1) begin
      errors++;
      $display("FAIL wr_one_cycle: ack_cycles=%0d we=%b beats=%0d required 2 0 1",
               cyc, ddr_we, wr_accepts - w0);
    end
  endtask

  task automatic test_write_busy();
    int cyc; bit st; logic fwe; logic [28:0] fa; logic [7:0] fb; logic [63:0] fd;
    issue_write(25'h000010, 16'(($urandom)), 5, cyc, st, fwe, fa, fb, fd);
    busy_cycles = 0;
    checks++;
    if (cyc !== 7 || st !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy_hold: ack_cycles=%0d stable=%b required 7 1", cyc, st);
    end
    checks++;
    if (fa !== 29'h0600002 || fb !== 8'h03) begin
      errors++;
      $display("FAIL wr_busy_addr: addr=%h be=%h required 0600002 03", fa, fb);
    end
  endtask

  task automatic test_read_miss();
    logic [15:0] d; int cyc, nr; bit mm, aor; logic frd; logic [28:0] fa;
    ddr_mem[int'(BASE + 29'd1)] = 64'h4444_3333_2222_1111;
    wmodel[4] = 16'h1111; wmodel[5] = 16'h2222; wmodel[6] = 16'h3333; wmodel[7] = 16'h4444;
    rd_latency = 7;
    issue_read(22'h000005, d, cyc, nr, mm, aor, frd, fa);
    checks++;
    if (frd !== 1'b1 || fa !== 29'h0600001 || nr !== 1) begin
      errors++;
      $display("FAIL rd_miss_issue: rd=%b addr=%h beats=%0d required 1 0600001 1", frd, fa, nr);
    end
    checks++;
    if (d !== 16'h2222) begin
      errors++;
      $display("FAIL rd_miss_data: dout=%h required 2222", d);
    end
    checks++;
    if (aor !== 1'b1 || cyc !== 9) begin
      errors++;
      $display("FAIL rd_miss_ack_edge: on_ready=%b cycles=%0d required 1 9", aor, cyc);
    end
  endtask

  task automatic test_cache_hits();
    logic [15:0] d; int cyc, nr; bit mm, aor; logic frd; logic [28:0] fa;
    logic [15:0] exp_d [2] = '{16'h3333, 16'h4444};
    logic [21:0] adr   [2] = '{22'h000006, 22'h000007};
    for (int i = 0; i < 2; i++) begin
      issue_read(adr[i], d, cyc, nr, mm, aor, frd, fa);
      checks++;
      if (d !== exp_d[i] || cyc !== 1 || nr !== 0 || frd !== 1'b0) begin
        errors++;
        $display("FAIL rd_hit_%0d: dout=%h cycles=%0d beats=%0d required %h 1 0",
                 i, d, cyc, nr, exp_d[i]);
      end
    end
  endtask

  task automatic test_write_invalidate();
    int cyc, nr; bit st, mm, aor; logic fwe, frd; logic [28:0] fa; logic [7:0] fb;
    logic [63:0] fd; logic [15:0] d;
    logic [15:0] nd = 16'hBEEF;
    issue_write(25'h00000E, nd, 0, cyc, st, fwe, fa, fb, fd);
    issue_read(22'h000007, d, cyc, nr, mm, aor, frd, fa);
    checks++;
    if (nr !== 1 || fa !== 29'h0600001) begin
      errors++;
      $display("FAIL inval_miss: beats=%0d addr=%h required 1 0600001", nr, fa);
    end
    checks++;
    if (d !== nd) begin
      errors++;
      $display("FAIL inval_data: dout=%h required %h", d, nd);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] d; int cyc, nr; bit mm, aor; logic frd; logic [28:0] fa;
    rd_latency = 7;
    rdaddr = 22'h000100;
    rd_req = ~rd_req;
    repeat (2) tick();
    reset  = 1'b1;
    rd_req = 1'b0;
    we_req = 1'b0;
    tick();
    reset  = 1'b0;
    m_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (rd_ack !== 1'b0 || ddr_rd !== 1'b0 || ddr_we !== 1'b0 || dout !== 16'd0) begin
      errors++;
      $display("FAIL stray_beat: rd_ack=%b rd=%b we=%b dout=%h required 0 0 0 0000",
               rd_ack, ddr_rd, ddr_we, dout);
    end
    issue_read(22'h000100, d, cyc, nr, mm, aor, frd, fa);
    checks++;
    if (frd !== 1'b1 || nr !== 1 || d !== model_word(32'h100)) begin
      errors++;
      $display("FAIL post_reset_miss: rd=%b beats=%0d dout=%h required 1 1 %h",
               frd, nr, d, model_word(32'h100));
    end
  endtask

  task automatic test_both_pending();
    int we_t = 0, rd_t = 0, cyc = 0;
    logic pw, pr;
    logic [15:0] nd = 16'(($urandom));
    txn_log.delete();
    busy_cycles = 1;
    rd_latency  = 3;
    wraddr = 25'h000020;
    din    = nd;
    rdaddr = 22'h000030;
    wmodel[16] = nd;
    if (m_valid && m_line == 4) m_valid = 1'b0;
    we_req = ~we_req;
    rd_req = ~rd_req;
    pw = we_ack; pr = rd_ack;
    do begin
      tick();
      cyc++;
      if (we_ack !== pw) we_t++;
      if (rd_ack !== pr) rd_t++;
      pw = we_ack; pr = rd_ack;
    end while ((we_ack !== we_req || rd_ack !== rd_req) && cyc < 200);
    repeat (5) begin
      tick();
      if (we_ack !== pw) we_t++;
      if (rd_ack !== pr) rd_t++;
      pw = we_ack; pr = rd_ack;
    end
    m_valid = 1'b1;
    m_line  = 12;
    checks++;
    if (txn_log.size() !== 2 || txn_log[0] !== "W" || txn_log[1] !== "R") begin
      errors++;
      $display("FAIL both_order: txns=%0d first=%s required 2 W", txn_log.size(),
               txn_log.size() > 0 ? string'(txn_log[0]) : "-");
    end
    checks++;
    if (we_t !== 1 || rd_t !== 1) begin
      errors++;
      $display("FAIL both_acks: we_toggles=%0d rd_toggles=%0d required 1 1", we_t, rd_t);
    end
    checks++;
    if (dout !== model_word(32'h30)) begin
      errors++;
      $display("FAIL both_data: dout=%h required %h", dout, model_word(32'h30));
    end
  endtask

  task automatic test_random();
    int cyc, nr; bit st, mm, aor; logic fwe, frd; logic [28:0] fa; logic [7:0] fb;
    logic [63:0] fd; logic [15:0] d; logic [21:0] ra;
    for (int i = 0; i < 60; i++) begin
      busy_cycles = $urandom_range(0, 3);
      rd_latency  = $urandom_range(1, 6);
      if ($urandom_range(0, 2) == 0) begin
        issue_write({19'd0, 5'($urandom_range(0, 31)), 1'b0}, 16'($urandom),
                    busy_cycles, cyc, st, fwe, fa, fb, fd);
      end else begin
        ra = 22'($urandom_range(0, 31));
        issue_read(ra, d, cyc, nr, mm, aor, frd, fa);
        checks++;
        if (d !== model_word(int'(ra))) begin
          errors++;
          $display("FAIL rand_data_%0d: addr=%h dout=%h required %h", i, ra, d, model_word(int'(ra)));
        end
        checks++;
        if ((mm && nr !== 1) || (nr == 0 && cyc !== 1)) begin
          errors++;
          $display("FAIL rand_cache_%0d: addr=%h beats=%0d cycles=%0d required_miss=%b",
                   i, ra, nr, cyc, mm);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_busy();
    test_read_miss();
    test_cache_hits();
    test_write_invalidate();
    test_reset_mid_read();
    test_both_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
